// File: rtl/uart_rx_deserializer_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states and
// default timing constants used by uart_rx_deserializer and its users.
package uart_rx_deserializer_pkg;

  // 25 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int DEFAULT_DATA_WIDTH   = 8;

  // Receiver FSM states. Codes are fixed so the debug output is stable.
  typedef enum logic [2:0] {
    RXIdle  = 3'd0,
    RXStart = 3'd1,
    RXData  = 3'd2,
    RXStop  = 3'd3,
    RXBreak = 3'd4
  } UARTRxState;

  // Offset from the start-bit falling edge to the middle of the bit.
  function automatic int mid_count(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. The reset value is a
// parameter so idle-high lines (such as a UART rx pin) do not produce a
// false edge when reset is released.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receive front end. Synchronizes rx_in, validates the start bit
// at mid-bit, samples data bits LSB first, checks the stop bit and hands
// each good byte to the consumer.
//
// Handshake: rx_complete is the valid, rx_ack is the ready. A byte is
// transferred on every clock where both are high; rx_complete then drops
// on the next clock unless a new good byte lands in that same cycle.
// rx_byte is stable whenever rx_complete is high. rx_ack while
// rx_complete is low has no effect.
//
// CLKS_PER_BIT must be at least 4 so the mid-bit offset is non-trivial.
module uart_rx_deserializer
  import uart_rx_deserializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  rx_ack,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_complete,
  output logic                  framing_error,
  output logic                  overrun,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int MID   = mid_count(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID_LAST = CNT_W'(MID - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_WIDTH - 1);

  UARTRxState            state;
  logic                  rx_s;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;

  // Line idles high, so the synchronizer presets to 1.
  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx_in),
    .q    (rx_s)
  );

  assign busy      = (state != RXIdle);
  assign state_dbg = state;

  // Receiver FSM with inline baud counter, bit index and shift register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= RXIdle;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      rx_byte       <= '0;
      rx_complete   <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      // Consumer took the byte; a store below in the same cycle wins.
      if (rx_ack) begin
        rx_complete <= 1'b0;
      end

      case (state)
        RXIdle: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= RXStart;
          end
        end

        RXStart: begin
          if (cnt == CNT_MID_LAST) begin
            if (rx_s) begin
              // Line went back high before mid start bit: glitch.
              state <= RXIdle;
            end else begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= RXData;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RXData: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            // Shift in from the top so the first (LSB) bit ends in bit 0.
            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
            bit_idx   <= bit_idx + BIT_W'(1);
            if (bit_idx == BIT_LAST) begin
              state <= RXStop;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RXStop: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              if (!rx_complete || rx_ack) begin
                rx_byte     <= shift_reg;
                rx_complete <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= RXIdle;
            end else begin
              framing_error <= 1'b1;
              state         <= RXBreak;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RXBreak: begin
          // Hold here through a long low (break) so it is not re-framed.
          if (rx_s) begin
            state <= RXIdle;
          end
        end

        default: begin
          state <= RXIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer at CLKS_PER_BIT = 8.
module tb_uart_rx_deserializer;
  import uart_rx_deserializer_pkg::*;

  localparam int CPB = 8;
  localparam int W   = 8;

  logic         clock;
  logic         reset;
  logic         rx_in;
  logic         rx_ack;
  logic [W-1:0] rx_byte;
  logic         rx_complete;
  logic         framing_error;
  logic         overrun;
  logic         busy;
  logic [2:0]   state_dbg;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b;
  logic         prev_c = 1'b0;
  logic [W-1:0] prev_b = '0;
  logic         prev_fe = 1'b0;
  int           fe_count = 0;
  int           fe_high = 0;

  uart_rx_deserializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_ack       (rx_ack),
    .rx_byte      (rx_byte),
    .rx_complete  (rx_complete),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: a byte is delivered when rx_complete rises or rx_byte
  // changes while rx_complete stays high.
  always @(negedge clock) begin
    if (rx_complete && (!prev_c || rx_byte != prev_b)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h, expected no byte", rx_byte);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_byte !== exp_b) begin
          errors++;
          $display("FAIL sb_byte: got %h, expected %h", rx_byte, exp_b);
        end
      end
    end
    prev_c = rx_complete;
    prev_b = rx_byte;
  end

  // Framing-error pulse monitor
  always @(negedge clock) begin
    if (framing_error) fe_high++;
    if (framing_error && !prev_fe) fe_count++;
    prev_fe = framing_error;
  end

  // Driver tasks
  task automatic wait_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic stop_bit,
                            input bit ack_at_stop);
    rx_in = 1'b0;
    repeat (CPB) wait_clk();
    for (int i = 0; i < W; i++) begin
      rx_in = data[i];
      repeat (CPB) wait_clk();
    end
    rx_in = stop_bit;
    if (ack_at_stop) begin
      // Makes rx_ack high exactly on the stop-bit sample edge.
      repeat (CPB - 2) wait_clk();
      rx_ack = 1'b1;
      wait_clk();
      rx_ack = 1'b0;
      wait_clk();
    end else begin
      repeat (CPB) wait_clk();
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    wait_clk();
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_in = 1'b1;
    rx_ack = 1'b0;
    repeat (3) wait_clk();
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %h expected 00", rx_byte); end
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL rst_complete: got %b expected 0", rx_complete); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL rst_fe: got %b expected 0", framing_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (state_dbg !== RXIdle) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, RXIdle); end
    reset = 1'b1;
    repeat (4) wait_clk();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_frame();
    int fe0;
    fe0 = fe_count;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++; if (rx_complete !== 1'b1) begin errors++; $display("FAIL single_complete: got %b expected 1", rx_complete); end
    checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h expected a5", rx_byte); end
    checks++; if (fe_count !== fe0) begin errors++; $display("FAIL single_fe: got %0d pulses expected 0", fe_count - fe0); end
    pulse_ack();
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL single_ack_clear: got %b expected 0", rx_complete); end
    // Ack with nothing pending must be ignored.
    rx_ack = 1'b1;
    repeat (3) wait_clk();
    rx_ack = 1'b0;
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL idle_ack_complete: got %b expected 0", rx_complete); end
    checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL idle_ack_byte: got %h expected a5", rx_byte); end
    repeat (2 * CPB) wait_clk();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    fork
      begin
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
      end
      begin
        for (int n = 0; n < 2; n++) begin
          int waited;
          waited = 0;
          while (rx_complete !== 1'b1 && waited < 20 * CPB) begin
            wait_clk();
            waited++;
          end
          checks++;
          if (rx_complete !== 1'b1) begin
            errors++;
            $display("FAIL b2b_timeout: got no rx_complete for byte %0d, expected one", n);
          end
          repeat (2) wait_clk();
          pulse_ack();
        end
      end
    join
    wait_clk();
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL b2b_complete: got %b expected 0", rx_complete); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d queued expected 0", exp_q.size()); end
    repeat (2 * CPB) wait_clk();
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected 0", overrun); end
    send_frame(8'h22, 1'b1, 1'b0);
    checks++; if (rx_byte !== 8'h11) begin errors++; $display("FAIL ovr_byte: got %h expected 11", rx_byte); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (rx_complete !== 1'b1) begin errors++; $display("FAIL ovr_complete: got %b expected 1", rx_complete); end
    pulse_ack();
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear: got %b expected 0", rx_complete); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    repeat (2 * CPB) wait_clk();
  endtask

  task automatic test_framing_break();
    int fe0;
    int fh0;
    fe0 = fe_count;
    fh0 = fe_high;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (30 * CPB) wait_clk();
    checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL brk_fe_pulses: got %0d expected 1", fe_count - fe0); end
    checks++; if (fe_high - fh0 !== 1) begin errors++; $display("FAIL brk_fe_width: got %0d cycles expected 1", fe_high - fh0); end
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL brk_complete: got %b expected 0", rx_complete); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy: got %b expected 1", busy); end
    checks++; if (state_dbg !== RXBreak) begin errors++; $display("FAIL brk_state: got %0d expected %0d", state_dbg, RXBreak); end
    rx_in = 1'b1;
    repeat (4) wait_clk();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_release: got %b expected 0", busy); end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    checks++; if (rx_byte !== 8'h0F) begin errors++; $display("FAIL brk_next_byte: got %h expected 0f", rx_byte); end
    checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL brk_next_fe: got %0d expected 1", fe_count - fe0); end
    pulse_ack();
    repeat (2 * CPB) wait_clk();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_count;
    rx_in = 1'b0;
    repeat (2) wait_clk();
    rx_in = 1'b1;
    repeat (2) wait_clk();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_detect: got %b expected 1", busy); end
    repeat (10) wait_clk();
    checks++; if (state_dbg !== RXIdle) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", state_dbg, RXIdle); end
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL glitch_complete: got %b expected 0", rx_complete); end
    checks++; if (fe_count !== fe0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_count - fe0); end
    repeat (2 * CPB) wait_clk();
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] partial;
    int fe0;
    partial = 8'h5A;
    rx_in = 1'b0;
    repeat (CPB) wait_clk();
    for (int i = 0; i < 4; i++) begin
      rx_in = partial[i];
      repeat (CPB) wait_clk();
    end
    rx_in = partial[4];
    repeat (CPB / 2) wait_clk();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (2) wait_clk();
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL mid_rst_byte: got %h expected 00", rx_byte); end
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL mid_rst_complete: got %b expected 0", rx_complete); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    reset = 1'b1;
    fe0 = fe_count;
    repeat (2 * CPB) wait_clk();
    checks++; if (fe_count !== fe0) begin errors++; $display("FAIL mid_rst_fe: got %0d expected 0", fe_count - fe0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    checks++; if (rx_byte !== 8'h81) begin errors++; $display("FAIL mid_next_byte: got %h expected 81", rx_byte); end
    checks++; if (rx_complete !== 1'b1) begin errors++; $display("FAIL mid_next_complete: got %b expected 1", rx_complete); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b1);
    checks++; if (rx_byte !== 8'h7E) begin errors++; $display("FAIL simack_byte: got %h expected 7e", rx_byte); end
    checks++; if (rx_complete !== 1'b1) begin errors++; $display("FAIL simack_complete: got %b expected 1", rx_complete); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simack_overrun: got %b expected 0", overrun); end
    pulse_ack();
    checks++; if (rx_complete !== 1'b0) begin errors++; $display("FAIL simack_clear: got %b expected 0", rx_complete); end
    repeat (2 * CPB) wait_clk();
  endtask

  // Test sequence and final report
  initial begin
    reset  = 1'b0;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_framing_break();
    test_glitch();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d undelivered bytes expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
